magnitude_comparator: RTL and testbench
=======================================

Name: magnitude_comparator

Overview:
- Parameterised N-bit magnitude comparator producing mutually exclusive less/equal/greater flags.
- Combinational flags serve decode logic, e.g. the double-operation detector in the control unit, which compares opcode[3:0] against 4'd8 and 4'd9.
- A registered copy of the flags, qualified by a valid bit, serves pipeline-stage use.

Parameters:
- N, 32, operand width in bits; legal range 1..64; the control unit instantiates it with N=4.

Ports:
- clk  input  1  rising-edge clock for the registered outputs.
- rst_n  input  1  asynchronous active-low reset.
- a  input  N  left operand.
- b  input  N  right operand.
- valid_in  input  1  qualifies a/b for capture into the output register.
- less  output  1  combinational; 1 when a < b.
- equal  output  1  combinational; 1 when a == b.
- greater  output  1  combinational; 1 when a > b.
- less_q  output  1  registered less.
- equal_q  output  1  registered equal.
- greater_q  output  1  registered greater.
- valid_q  output  1  registered valid_in.

Interface (already decided):
- One clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Default comparison is unsigned.
- less, equal and greater are purely combinational from a and b; zero latency; not affected by rst_n or clk.
- Exactly one of less/equal/greater is 1 for every input combination, including all-zero, all-one and N=1.
- No X propagation for known inputs.
- Structure: bitwise equal/greater-than terms merged in a log2(N)-depth prefix tree.
  - Merge rule: gt = gt_hi | (eq_hi & gt_lo); eq = eq_hi & eq_lo.
  - less = ~eq & ~gt.
  - Odd or non-power-of-two N is padded internally with equal-valued high bits; the padding must not change the result.
- Registered path:
  - On rising clk with valid_in=1: less_q, equal_q, greater_q capture the current combinational flags, and valid_q <= 1.
  - With valid_in=0: valid_q <= 0 and the flag registers hold their previous values.
  - Latency is one cycle, with back-to-back captures every cycle.
- Reset:
  - rst_n=0 immediately (asynchronously) forces less_q=0, equal_q=0, greater_q=0, valid_q=0.
  - This is the only state in which the three _q flags may all be 0.
  - Reset asserted mid-stream discards the pending capture.
  - After rst_n deasserts, the first rising clk with valid_in=1 loads normally.
- Simultaneous operand change and clock edge: the values sampled at the edge are captured.

Optional Feature:
- Macro COMPARATOR_SIGNED_EN.
- When defined, adds input port signed_mode (1 bit, after valid_in).
  - signed_mode=1: a and b are compared as two's-complement. Implemented by inverting the MSB of both operands before the tree.
  - signed_mode=0: unsigned comparison.
  - signed_mode affects both the combinational and registered flags.
- When not defined: the port is absent and comparison is always unsigned.

Test Plan:
- N=4, a=4'd8, b=4'd8 -> less=0, equal=1, greater=0. Next edge with valid_in=1 -> equal_q=1, valid_q=1.
- N=4, a=4'd9, b=4'd8 -> greater=1. a=4'd1, b=4'd8 -> less=1. a=4'd0, b=4'd0 -> equal=1.
- Exhaustive sweep for N=4 (256 pairs) and random sweep for N=32 -> flags match a reference compare; exactly one flag is high every time.
- valid_in pulse pattern 1,0,1 with changing operands -> valid_q follows one cycle later; flag registers hold during the valid_in=0 cycle.
- Assert rst_n=0 between clock edges while valid_q=1 -> all _q outputs go to 0 without waiting for clk; combinational flags unaffected.
- With COMPARATOR_SIGNED_EN, N=4, a=4'b1000, b=4'b0001:
  - signed_mode=1 -> less=1.
  - signed_mode=0 -> greater=1.
  - Macro undefined -> greater=1.

Source files
------------

// File: rtl/magnitude_comparator.sv
// N-bit magnitude comparator: combinational less/equal/greater from a log2(N)-depth prefix tree,
// plus a valid-qualified registered copy. Optional signed compare via `define COMPARATOR_SIGNED_EN.
module magnitude_comparator #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         valid_in,
`ifdef COMPARATOR_SIGNED_EN
    input  logic         signed_mode,
`endif
    output logic         less,
    output logic         equal,
    output logic         greater,
    output logic         less_q,
    output logic         equal_q,
    output logic         greater_q,
    output logic         valid_q
);

    localparam int LOG   = (N > 1) ? $clog2(N) : 0;
    localparam int P     = 1 << LOG;
    localparam int NODES = 2 * P - 1;

    logic [N-1:0] w_a_cmp;
    logic [N-1:0] w_b_cmp;

`ifdef COMPARATOR_SIGNED_EN
    localparam logic [N-1:0] MSB_MASK = N'(64'd1 << (N - 1));

    // Flipping both sign bits maps two's-complement order onto unsigned order.
    assign w_a_cmp = signed_mode ? (a ^ MSB_MASK) : a;
    assign w_b_cmp = signed_mode ? (b ^ MSB_MASK) : b;
`else
    assign w_a_cmp = a;
    assign w_b_cmp = b;
`endif

    // Heap-ordered tree: leaf for bit j at index P-1+j; node i has hi child 2i+2, lo child 2i+1.
    logic [NODES-1:0] w_gt;
    logic [NODES-1:0] w_eq;

    // NOTE: defaulting every tree node first keeps always_comb latch-free and gives the padding leaves their neutral value.
    always_comb begin
        w_gt = '0;
        w_eq = '1;
        for (int j = 0; j < N; j++) begin
            w_gt[P-1+j] = w_a_cmp[j] & ~w_b_cmp[j];
            w_eq[P-1+j] = ~(w_a_cmp[j] ^ w_b_cmp[j]);
        end
        for (int i = P - 2; i >= 0; i--) begin
            w_gt[i] = w_gt[2*i+2] | (w_eq[2*i+2] & w_gt[2*i+1]);
            w_eq[i] = w_eq[2*i+2] & w_eq[2*i+1];
        end
    end

    assign equal   = w_eq[0];
    assign greater = w_gt[0];
    assign less    = ~w_eq[0] & ~w_gt[0];

    logic r_less_q;
    logic r_equal_q;
    logic r_greater_q;
    logic r_valid_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_less_q    <= 1'b0;
            r_equal_q   <= 1'b0;
            r_greater_q <= 1'b0;
            r_valid_q   <= 1'b0;
        end else begin
            r_valid_q <= valid_in;
            if (valid_in) begin
                r_less_q    <= less;
                r_equal_q   <= equal;
                r_greater_q <= greater;
            end
        end
    end

    assign less_q    = r_less_q;
    assign equal_q   = r_equal_q;
    assign greater_q = r_greater_q;
    assign valid_q   = r_valid_q;

endmodule

// File: tb/tb_magnitude_comparator.sv
// Self-checking bench for magnitude_comparator at N=4, 32, 5 and 1 against an arithmetic reference model.
module tb_magnitude_comparator;

`ifdef COMPARATOR_SIGNED_EN
    localparam int SGN_MAX = 1;
`else
    localparam int SGN_MAX = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_in = 1'b0;
    logic sgn = 1'b0;

    logic [3:0]  a4 = '0, b4 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [4:0]  a5 = '0, b5 = '0;
    logic [0:0]  a1 = '0, b1 = '0;

    // Flag vectors are {less, equal, greater}.
    logic [2:0] f4, fq4, f32, fq32, f5, fq5, f1, fq1;
    logic       vq4, vq32, vq5, vq1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    magnitude_comparator #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .valid_in(valid_in),
`ifdef COMPARATOR_SIGNED_EN
        .signed_mode(sgn),
`endif
        .less(f4[2]), .equal(f4[1]), .greater(f4[0]),
        .less_q(fq4[2]), .equal_q(fq4[1]), .greater_q(fq4[0]), .valid_q(vq4)
    );

    magnitude_comparator #(.N(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .valid_in(valid_in),
`ifdef COMPARATOR_SIGNED_EN
        .signed_mode(sgn),
`endif
        .less(f32[2]), .equal(f32[1]), .greater(f32[0]),
        .less_q(fq32[2]), .equal_q(fq32[1]), .greater_q(fq32[0]), .valid_q(vq32)
    );

    magnitude_comparator #(.N(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .a(a5), .b(b5), .valid_in(valid_in),
`ifdef COMPARATOR_SIGNED_EN
        .signed_mode(sgn),
`endif
        .less(f5[2]), .equal(f5[1]), .greater(f5[0]),
        .less_q(fq5[2]), .equal_q(fq5[1]), .greater_q(fq5[0]), .valid_q(vq5)
    );

    magnitude_comparator #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .valid_in(valid_in),
`ifdef COMPARATOR_SIGNED_EN
        .signed_mode(sgn),
`endif
        .less(f1[2]), .equal(f1[1]), .greater(f1[0]),
        .less_q(fq1[2]), .equal_q(fq1[1]), .greater_q(fq1[0]), .valid_q(vq1)
    );

    // Reference: interpret operands as integers (optionally two's-complement) and compare arithmetically.
    function automatic logic [2:0] ref_flags(longint unsigned x, longint unsigned y, int n, logic s);
        longint xs, ys;
        xs = longint'(x);
        ys = longint'(y);
        if (s && x[n-1]) xs = xs - (longint'(1) << n);
        if (s && y[n-1]) ys = ys - (longint'(1) << n);
        if (xs < ys)       return 3'b100;
        else if (xs == ys) return 3'b010;
        else               return 3'b001;
    endfunction

    task automatic test_reset();
        #3;
        checks++;
        if ({fq4, vq4, fq32, vq32, fq5, vq5, fq1, vq1} !== 16'h0) begin
            errors++;
            $display("FAIL reset_q: got %b%b %b%b %b%b %b%b, want all zero",
                     fq4, vq4, fq32, vq32, fq5, vq5, fq1, vq1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [3:0] ta [4] = '{4'd8, 4'd9, 4'd1, 4'd0};
        logic [3:0] tb [4] = '{4'd8, 4'd8, 4'd8, 4'd0};
        logic [2:0] te [4] = '{3'b010, 3'b001, 3'b100, 3'b010};
        sgn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a4 = ta[k];
            b4 = tb[k];
            valid_in = 1'b1;
            #1;
            checks++;
            if (f4 !== te[k]) begin
                errors++;
                $display("FAIL directed_comb a=%0d b=%0d: got %b want %b", ta[k], tb[k], f4, te[k]);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({fq4, vq4} !== {te[k], 1'b1}) begin
                errors++;
                $display("FAIL directed_reg a=%0d b=%0d: got %b/%b want %b/1", ta[k], tb[k], fq4, vq4, te[k]);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [2:0] exp;
        @(negedge clk);
        valid_in = 1'b0;
        for (int s = 0; s <= SGN_MAX; s++) begin
            sgn = 1'(s);
            for (int x = 0; x < 32; x++) begin
                for (int y = 0; y < 32; y++) begin
                    a5 = 5'(x);
                    b5 = 5'(y);
                    a4 = 4'(x);
                    b4 = 4'(y);
                    a1 = 1'(x);
                    b1 = 1'(y);
                    #1;
                    exp = ref_flags(longint'(x), longint'(y), 5, sgn);
                    checks++;
                    if (f5 !== exp || !$onehot(f5)) begin
                        errors++;
                        $display("FAIL sweep_n5 s=%0d a=%0d b=%0d: got %b want %b", s, x, y, f5, exp);
                    end
                    if (x < 16 && y < 16) begin
                        exp = ref_flags(longint'(x), longint'(y), 4, sgn);
                        checks++;
                        if (f4 !== exp || !$onehot(f4)) begin
                            errors++;
                            $display("FAIL sweep_n4 s=%0d a=%0d b=%0d: got %b want %b", s, x, y, f4, exp);
                        end
                    end
                    if (x < 2 && y < 2) begin
                        exp = ref_flags(longint'(x), longint'(y), 1, sgn);
                        checks++;
                        if (f1 !== exp || !$onehot(f1)) begin
                            errors++;
                            $display("FAIL sweep_n1 s=%0d a=%0d b=%0d: got %b want %b", s, x, y, f1, exp);
                        end
                    end
                end
            end
        end
        sgn = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_c;
        logic [2:0] exp_fq = 3'b000;
        logic       exp_vq;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a32 = $urandom;
            case (i % 5)
                0:       b32 = a32;
                1:       b32 = a32 ^ (32'd1 << $urandom_range(31, 0));
                2:       b32 = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
                default: b32 = $urandom;
            endcase
            valid_in = (i == 0) ? 1'b1 : 1'($urandom_range(1, 0));
            sgn = (SGN_MAX != 0) ? 1'($urandom_range(1, 0)) : 1'b0;
            #1;
            exp_c = ref_flags(longint'(a32), longint'(b32), 32, sgn);
            checks++;
            if (f32 !== exp_c || !$onehot(f32)) begin
                errors++;
                $display("FAIL rand_comb i=%0d a=%h b=%h s=%0d: got %b want %b", i, a32, b32, sgn, f32, exp_c);
            end
            if (valid_in) exp_fq = exp_c;
            exp_vq = valid_in;
            @(posedge clk);
            #1;
            checks++;
            if ({fq32, vq32} !== {exp_fq, exp_vq}) begin
                errors++;
                $display("FAIL rand_reg i=%0d: got %b/%b want %b/%b", i, fq32, vq32, exp_fq, exp_vq);
            end
        end
        sgn = 1'b0;
    endtask

    task automatic test_valid_pulse();
        logic [3:0] pa [3] = '{4'd3, 4'd7, 4'd5};
        logic [3:0] pb [3] = '{4'd7, 4'd3, 4'd5};
        logic       pv [3] = '{1'b1, 1'b0, 1'b1};
        logic [2:0] exp_fq = 3'b000;
        logic [2:0] exp_c;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a4 = pa[k];
            b4 = pb[k];
            valid_in = pv[k];
            exp_c = ref_flags(longint'(pa[k]), longint'(pb[k]), 4, 1'b0);
            if (pv[k]) exp_fq = exp_c;
            @(posedge clk);
            #1;
            checks++;
            if ({fq4, vq4} !== {exp_fq, pv[k]}) begin
                errors++;
                $display("FAIL valid_pulse k=%0d: got %b/%b want %b/%b", k, fq4, vq4, exp_fq, pv[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a4 = 4'd12;
        b4 = 4'd2;
        valid_in = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fq4, vq4, fq32, vq32} !== 8'h0 || f4 !== 3'b001) begin
            errors++;
            $display("FAIL async_reset: q=%b%b %b%b comb=%b want q=0 comb=001", fq4, vq4, fq32, vq32, f4);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({fq4, vq4} !== 4'h0) begin
            errors++;
            $display("FAIL reset_hold: got %b/%b want 000/0", fq4, vq4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({fq4, vq4} !== 4'h0) begin
            errors++;
            $display("FAIL reset_release: got %b/%b want 000/0", fq4, vq4);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({fq4, vq4} !== 4'b0011) begin
            errors++;
            $display("FAIL first_load: got %b/%b want 001/1", fq4, vq4);
        end
    endtask

    task automatic test_signed();
        @(negedge clk);
        valid_in = 1'b0;
        a4 = 4'b1000;
        b4 = 4'b0001;
`ifdef COMPARATOR_SIGNED_EN
        sgn = 1'b1;
        #1;
        checks++;
        if (f4 !== 3'b100) begin
            errors++;
            $display("FAIL signed_mode1: got %b want 100", f4);
        end
        sgn = 1'b0;
`endif
        #1;
        checks++;
        if (f4 !== 3'b001) begin
            errors++;
            $display("FAIL signed_mode0: got %b want 001", f4);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_exhaustive();
        test_back_to_back();
        test_valid_pulse();
        test_async_reset();
        test_signed();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
